// File: rtl/caliptra_prim_alert_pkg.sv
// ---------------------------------------------------------------------------
// caliptra_prim_alert_pkg
//
// Purpose:
//   Shared types for the differential alert protocol between an alert
//   sender and an alert receiver.
//
//   alert_tx_t : sender -> receiver, alert_p/alert_n differential pair.
//   alert_rx_t : receiver -> sender, ping_p/ping_n and ack_p/ack_n
//                differential pairs.
//
//   DIFF_PAIR_RESET is the {n,p} reset pattern for any differential pair
//   in this protocol: p low, n high, which is the idle level of the pair.
// ---------------------------------------------------------------------------
package caliptra_prim_alert_pkg;

    typedef struct packed {
        logic alert_p;
        logic alert_n;
    } alert_tx_t;

    typedef struct packed {
        logic ping_p;
        logic ping_n;
        logic ack_p;
        logic ack_n;
    } alert_rx_t;

    localparam logic [1:0] DIFF_PAIR_RESET = 2'b10;

endpackage

// File: rtl/caliptra_prim_diff_decode.sv
// ---------------------------------------------------------------------------
// caliptra_prim_diff_decode
//
// Purpose:
//   Decodes a differential pair into a level and a signal-integrity error
//   flag. With AsyncOn set the pair first passes through a two-stage
//   synchroniser (both halves moved together so they stay aligned), which
//   delays level_o/sigint_o by two cycles. With AsyncOn clear the decode is
//   purely combinational.
//
// Ports:
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset (synchroniser only)
//   diff_pi  : positive half of the pair
//   diff_ni  : negative half of the pair
//   level_o  : decoded level (the positive half)
//   sigint_o : high whenever both halves carry the same value
// ---------------------------------------------------------------------------
module caliptra_prim_diff_decode
    import caliptra_prim_alert_pkg::*;
#(
    parameter logic AsyncOn = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic diff_pi,
    input  logic diff_ni,
    output logic level_o,
    output logic sigint_o
);

    logic w_p;
    logic w_n;

    if (AsyncOn) begin : gen_async
        // Both stages store {n,p}; resetting to the idle pattern keeps the
        // synchronised pair differential so no false integrity error is
        // seen right after reset.
        logic [1:0] r_stage1;
        logic [1:0] r_stage2;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_stage1 <= DIFF_PAIR_RESET;
                r_stage2 <= DIFF_PAIR_RESET;
            end else begin
                r_stage1 <= {diff_ni, diff_pi};
                r_stage2 <= r_stage1;
            end
        end

        assign w_p = r_stage2[0];
        assign w_n = r_stage2[1];
    end else begin : gen_sync
        assign w_p = diff_pi;
        assign w_n = diff_ni;
    end

    assign level_o  = w_p;
    assign sigint_o = (w_p == w_n);

endmodule

// File: rtl/caliptra_prim_sec_anchor_flop.sv
// ---------------------------------------------------------------------------
// caliptra_prim_sec_anchor_flop
//
// Purpose:
//   Plain register kept as its own module so that the two halves of a
//   differential pair live in a dedicated flop instance. Because each
//   pair has its own anchor, optimisation cannot collapse the n half
//   into an inverted copy of the p half.
//
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   d_i     : next value
//   q_o     : registered value (ResetValue while in reset)
// ---------------------------------------------------------------------------
module caliptra_prim_sec_anchor_flop #(
    parameter int                Width      = 2,
    parameter logic [Width-1:0]  ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] r_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_q <= ResetValue;
        end else begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/caliptra_prim_alert_receiver.sv
// ---------------------------------------------------------------------------
// caliptra_prim_alert_receiver
//
// Purpose:
//   Receiver side of the differential alert handshake. An incoming alert
//   level is acknowledged on the ack pair; the sender drops the alert and
//   the receiver drops ack, then two pause cycles separate handshakes.
//   A ping request toggles the ping pair; the next completed handshake is
//   then reported as ping_ok_o instead of alert_o. A non-differential alert
//   pair is flagged on integ_fail_o and forces the handshake back to idle.
//
// Ports:
//   clk_i        : clock
//   rst_ni       : synchronous active-low reset
//   ping_req_i   : request one ping of the remote sender
//   ping_ok_o    : one-cycle pulse, pending ping answered
//   alert_o      : one-cycle pulse, genuine alert received
//   integ_fail_o : high while the alert pair is non-differential
//   alert_rx_o   : ping and ack pairs toward the sender
//   alert_tx_i   : alert pair from the sender
// ---------------------------------------------------------------------------
module caliptra_prim_alert_receiver
    import caliptra_prim_alert_pkg::*;
#(
    parameter logic AsyncOn = 1'b1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      ping_req_i,
    output logic      ping_ok_o,
    output logic      alert_o,
    output logic      integ_fail_o,
    output alert_rx_t alert_rx_o,
    input  alert_tx_t alert_tx_i
);

    // Sparse encoding: every pair of legal states differs in four bits, so
    // a single upset lands in an illegal code and falls back to Idle.
    typedef enum logic [5:0] {
        Idle      = 6'b011001,
        HsAckWait = 6'b100101,
        Pause0    = 6'b110010,
        Pause1    = 6'b001110
    } state_e;

    state_e     r_state;
    state_e     w_state_d;

    logic       w_alert_level;
    logic       w_alert_sigint;

    logic       r_ping_pending;
    logic       w_ping_pending_d;
    logic       w_ping_toggle;

    logic       r_alert;
    logic       r_ping_ok;
    logic       r_integ_fail;
    logic       w_alert_d;
    logic       w_ping_ok_d;

    logic       w_ack_p_d;
    logic       w_ack_n_d;

    // Anchor flop contents are {n,p}.
    logic [1:0] w_ping_q;
    logic [1:0] w_ping_d;
    logic [1:0] w_ack_q;

    caliptra_prim_diff_decode #(
        .AsyncOn (AsyncOn)
    ) u_decode_alert (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .diff_pi  (alert_tx_i.alert_p),
        .diff_ni  (alert_tx_i.alert_n),
        .level_o  (w_alert_level),
        .sigint_o (w_alert_sigint)
    );

    // A ping is only launched when none is outstanding; an integrity error
    // also drops the request because it wipes the pending bookkeeping.
    // Toggling both halves keeps the ping pair differential at all times.
    assign w_ping_toggle = ping_req_i & ~r_ping_pending & ~w_alert_sigint;
    assign w_ping_d      = w_ping_toggle ? ~w_ping_q : w_ping_q;

    // Handshake FSM. The ping_ok/alert decision is made only on entry to
    // HsAckWait, using the pending flag as it stood before this cycle's
    // ping request. An integrity error overrides everything afterwards.
    always_comb begin
        w_state_d   = r_state;
        w_ack_p_d   = 1'b0;
        w_alert_d   = 1'b0;
        w_ping_ok_d = 1'b0;

        unique case (r_state)
            Idle: begin
                if (w_alert_level) begin
                    w_state_d = HsAckWait;
                    w_ack_p_d = 1'b1;
                    if (r_ping_pending) begin
                        w_ping_ok_d = 1'b1;
                    end else begin
                        w_alert_d = 1'b1;
                    end
                end
            end
            HsAckWait: begin
                if (w_alert_level) begin
                    w_ack_p_d = 1'b1;
                end else begin
                    w_state_d = Pause0;
                end
            end
            Pause0: begin
                w_state_d = Pause1;
            end
            Pause1: begin
                w_state_d = Idle;
            end
            default: begin
                w_state_d = Idle;
            end
        endcase

        if (w_alert_sigint) begin
            w_state_d   = Idle;
            w_ack_p_d   = 1'b0;
            w_alert_d   = 1'b0;
            w_ping_ok_d = 1'b0;
        end

        // In Idle with a broken alert pair, ack is deliberately made
        // non-differential so the sender sees the fault on its own inputs.
        w_ack_n_d = ~w_ack_p_d;
        if (w_alert_sigint && (r_state == Idle)) begin
            w_ack_n_d = 1'b0;
        end
    end

    // Pending ping is consumed by ping_ok, cleared by an integrity error
    // and otherwise armed by a request; a request while already pending
    // leaves the flag set and is simply lost.
    always_comb begin
        w_ping_pending_d = r_ping_pending | ping_req_i;
        if (w_alert_sigint || w_ping_ok_d) begin
            w_ping_pending_d = 1'b0;
        end
    end

    // State and pulse outputs; everything visible to the outside is
    // registered so outputs move one cycle after the deciding condition.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state        <= Idle;
            r_ping_pending <= 1'b0;
            r_alert        <= 1'b0;
            r_ping_ok      <= 1'b0;
            r_integ_fail   <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_ping_pending <= w_ping_pending_d;
            r_alert        <= w_alert_d;
            r_ping_ok      <= w_ping_ok_d;
            r_integ_fail   <= w_alert_sigint;
        end
    end

    caliptra_prim_sec_anchor_flop #(
        .Width      (2),
        .ResetValue (DIFF_PAIR_RESET)
    ) u_ping_flop (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (w_ping_d),
        .q_o    (w_ping_q)
    );

    caliptra_prim_sec_anchor_flop #(
        .Width      (2),
        .ResetValue (DIFF_PAIR_RESET)
    ) u_ack_flop (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    ({w_ack_n_d, w_ack_p_d}),
        .q_o    (w_ack_q)
    );

    assign alert_rx_o.ping_p = w_ping_q[0];
    assign alert_rx_o.ping_n = w_ping_q[1];
    assign alert_rx_o.ack_p  = w_ack_q[0];
    assign alert_rx_o.ack_n  = w_ack_q[1];

    assign alert_o      = r_alert;
    assign ping_ok_o    = r_ping_ok;
    assign integ_fail_o = r_integ_fail;

endmodule
